// File: rtl/bsg_cgol_output_serializer.sv
// Board-snapshot serializer for the CGoL pipeline.
// Takes the whole board from the controller in one cycle and acknowledges it
// with yumi_o. The board is then sent out as data_width_p-bit words on a
// ready/valid channel, lowest word first.
// Optional trailer word with the board population count is enabled by the
// macro BSG_CGOL_SERIALIZER_POPCOUNT_EN.
module bsg_cgol_output_serializer #(
    parameter int board_width_p = 32,
    parameter int data_width_p  = 16
) (
    input  logic                                     clk_i,
    input  logic                                     reset_n_i,
    input  logic [board_width_p*board_width_p-1:0]   board_i,
    input  logic                                     v_i,
    output logic                                     yumi_o,
    output logic [data_width_p-1:0]                  data_o,
    output logic                                     v_o,
    input  logic                                     ready_i
);

    localparam int cells_lp     = board_width_p * board_width_p;
    localparam int words_lp     = cells_lp / data_width_p;
    localparam int cnt_width_lp = ((words_lp + 1) == 1) ? 1 : $clog2(words_lp + 1);
    localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(words_lp - 1);

    // The board has to split into a whole number of output words.
    if ((cells_lp % data_width_p) != 0) begin : g_width_check
        $error("data_width_p must evenly divide board_width_p*board_width_p");
    end

`ifdef BSG_CGOL_SERIALIZER_POPCOUNT_EN
    typedef enum logic [1:0] {IDLE, SEND, TRAILER} state_e;

    localparam int pc_width_lp = $clog2(cells_lp + 1);

    function automatic logic [pc_width_lp-1:0] popcount(input logic [cells_lp-1:0] b);
        logic [pc_width_lp-1:0] sum;
        sum = '0;
        for (int unsigned i = 0; i < cells_lp; i++) begin
            sum = sum + pc_width_lp'(b[i]);
        end
        return sum;
    endfunction

    logic [data_width_p-1:0] pc_r;
`else
    typedef enum logic [1:0] {IDLE, SEND} state_e;
`endif

    state_e                  state_r;
    logic [cnt_width_lp-1:0] count_r;
    logic [cells_lp-1:0]     board_r;

    // Capture/handshake FSM; the board register shifts right so the current
    // word always sits in its low data_width_p bits.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
            count_r <= '0;
            board_r <= '0;
`ifdef BSG_CGOL_SERIALIZER_POPCOUNT_EN
            pc_r    <= '0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (v_i) begin
                        board_r <= board_i;
                        count_r <= '0;
                        state_r <= SEND;
`ifdef BSG_CGOL_SERIALIZER_POPCOUNT_EN
                        pc_r    <= data_width_p'(popcount(board_i));
`endif
                    end
                end
                SEND: begin
                    if (ready_i) begin
                        if (count_r == last_cnt_lp) begin
`ifdef BSG_CGOL_SERIALIZER_POPCOUNT_EN
                            state_r <= TRAILER;
`else
                            state_r <= IDLE;
`endif
                        end else begin
                            count_r <= count_r + cnt_width_lp'(1);
                            board_r <= board_r >> data_width_p;
                        end
                    end
                end
`ifdef BSG_CGOL_SERIALIZER_POPCOUNT_EN
                TRAILER: begin
                    if (ready_i) begin
                        state_r <= IDLE;
                    end
                end
`endif
                default: state_r <= IDLE;
            endcase
        end
    end

    // Outputs decode from state only; v_i reaches yumi_o, ready_i reaches nothing.
    always_comb begin
        yumi_o = 1'b0;
        v_o    = 1'b0;
        data_o = '0;
        case (state_r)
            IDLE: begin
                yumi_o = v_i & reset_n_i;
            end
            SEND: begin
                v_o    = 1'b1;
                data_o = board_r[data_width_p-1:0];
            end
`ifdef BSG_CGOL_SERIALIZER_POPCOUNT_EN
            TRAILER: begin
                v_o    = 1'b1;
                data_o = pc_r;
            end
`endif
            default: begin
                v_o    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bsg_cgol_output_serializer.sv
// Self-checking bench for bsg_cgol_output_serializer (4x4 board, 4-bit words).
module tb_bsg_cgol_output_serializer;

    logic        clk;
    logic        reset_n_i;
    logic [15:0] board_i;
    logic        v_i;
    logic        yumi_o;
    logic [3:0]  data_o;
    logic        v_o;
    logic        ready_i;

    int n_vec  = 0;
    int n_miss = 0;

    logic [3:0] exp_q[$];

    // w holds the expected output words, w[3:0] leaves first.
    typedef struct {
        logic [15:0] board;
        logic [7:0]  pat;
        logic [15:0] w;
        logic [3:0]  pc;
    } vec_t;

    vec_t tbl[6];

    bsg_cgol_output_serializer #(
        .board_width_p(4),
        .data_width_p (4)
    ) dut (
        .clk_i    (clk),
        .reset_n_i(reset_n_i),
        .board_i  (board_i),
        .v_i      (v_i),
        .yumi_o   (yumi_o),
        .data_o   (data_o),
        .v_o      (v_o),
        .ready_i  (ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output monitor: pops the scoreboard on each transfer, checks hold and no-gap.
    logic       hold_pending = 1'b0;
    logic [3:0] hold_data    = '0;
    logic       more_pending = 1'b0;
    logic [3:0] exp_w;

    always @(negedge clk) begin
        if (!reset_n_i) begin
            hold_pending = 1'b0;
            more_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_v", {31'b0, v_o}, 32'd1);
                check("hold_data", {28'b0, data_o}, {28'b0, hold_data});
            end
            if (more_pending) begin
                check("no_gap_v", {31'b0, v_o}, 32'd1);
            end
            hold_pending = 1'b0;
            more_pending = 1'b0;
            if (v_o) begin
                check("yumi_in_send", {31'b0, yumi_o}, 32'd0);
                if (ready_i) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_miss++;
                        $display("FAIL extra_word: got %0h expected none at %0t", data_o, $time);
                    end else begin
                        exp_w = exp_q.pop_front();
                        check("word", {28'b0, data_o}, {28'b0, exp_w});
                        more_pending = (exp_q.size() > 0);
                    end
                end else begin
                    hold_pending = 1'b1;
                    hold_data    = data_o;
                end
            end
        end
    end

    // Offer a board in IDLE, check the acknowledge, queue the expected words.
    task automatic capture(input logic [15:0] b, input logic [15:0] w, input logic [3:0] pc);
        v_i     = 1'b1;
        board_i = b;
        @(negedge clk);
        check("yumi_idle", {31'b0, yumi_o}, 32'd1);
        check("v_o_idle", {31'b0, v_o}, 32'd0);
        for (int k = 0; k < 4; k++) exp_q.push_back(w[k*4 +: 4]);
`ifdef BSG_CGOL_SERIALIZER_POPCOUNT_EN
        exp_q.push_back(pc);
`else
        if (pc != pc) exp_q.push_back(pc);
`endif
        @(posedge clk);
        #1;
        v_i = 1'b0;
    endtask

    // Apply a cycling ready pattern until all queued words have left.
    task automatic drain(input logic [7:0] pat, input logic nv, input logic [15:0] nb);
        logic [7:0] p;
        int k;
        bit done;
        p       = pat;
        k       = 0;
        done    = 1'b0;
        v_i     = nv;
        board_i = nb;
        ready_i = p[0];
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                done = 1'b1;
            end else begin
                k++;
                ready_i = p[k % 8];
            end
        end
        if (!done) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain_timeout: got %0d words left expected 0", exp_q.size());
            exp_q.delete();
        end
        check("v_o_after", {31'b0, v_o}, 32'd0);
        check("data_after", {28'b0, data_o}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{board: 16'hA5C3, pat: 8'hFF, w: 16'hA5C3, pc: 4'h8};
        tbl[1] = '{board: 16'hA5C3, pat: 8'hE9, w: 16'hA5C3, pc: 4'h8};
        tbl[2] = '{board: 16'hFFFF, pat: 8'h55, w: 16'hFFFF, pc: 4'h0};
        tbl[3] = '{board: 16'h0000, pat: 8'hFF, w: 16'h0000, pc: 4'h0};
        tbl[4] = '{board: 16'h1234, pat: 8'h33, w: 16'h1234, pc: 4'h5};
        tbl[5] = '{board: 16'h8001, pat: 8'hFE, w: 16'h8001, pc: 4'h2};

        // Reset held with v_i high: nothing may come out.
        reset_n_i = 1'b0;
        v_i       = 1'b1;
        board_i   = 16'hA5C3;
        ready_i   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_yumi", {31'b0, yumi_o}, 32'd0);
            check("rst_v", {31'b0, v_o}, 32'd0);
            check("rst_data", {28'b0, data_o}, 32'd0);
        end
        @(posedge clk);
        #1;
        reset_n_i = 1'b1;
        v_i       = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            capture(tbl[i].board, tbl[i].w, tbl[i].pc);
            drain(tbl[i].pat, 1'b0, 16'h0000);
            @(posedge clk);
            #1;
        end

        // v_i held high during SEND with the next board waiting.
        capture(16'hA5C3, 16'hA5C3, 4'h8);
        drain(8'hFF, 1'b1, 16'hFFFF);
        capture(16'hFFFF, 16'hFFFF, 4'h0);
        drain(8'hFF, 1'b0, 16'h0000);

        // Reset in the middle of a board aborts it.
        ready_i = 1'b1;
        capture(16'h1234, 16'h1234, 4'h5);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
`ifdef BSG_CGOL_SERIALIZER_POPCOUNT_EN
        check("abort_left", exp_q.size(), 32'd3);
`else
        check("abort_left", exp_q.size(), 32'd2);
`endif
        reset_n_i = 1'b0;
        v_i       = 1'b1;
        #1;
        check("abort_v", {31'b0, v_o}, 32'd0);
        check("abort_data", {28'b0, data_o}, 32'd0);
        check("abort_yumi", {31'b0, yumi_o}, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n_i = 1'b1;
        v_i       = 1'b0;
        @(posedge clk);
        #1;
        capture(16'h0001, 16'h0001, 4'h1);
        drain(8'hFF, 1'b0, 16'h0000);

        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
